// File: rtl/fifo8x9_pkg.sv
// Shared definitions for the FIFO8x9 sequencing controller: array geometry,
// occupancy-counter width and the controller state encoding.
package fifo8x9_pkg;

    localparam int FIFO_WIDTH = 9;
    localparam int FIFO_DEPTH = 8;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [2:0] {
        INIT_R  = 3'd0,
        INIT_W  = 3'd1,
        IDLE    = 3'd2,
        WR_DATA = 3'd3,
        WR_INC  = 3'd4,
        RD_DATA = 3'd5,
        RD_INC  = 3'd6
    } state_e;

endpackage

// File: rtl/fifo8x9_if.sv
// Push/pop handshake bundle between the surrounding logic (master) and the
// FIFO8x9 controller (slave).
interface fifo8x9_if #(
    parameter int WIDTH = 9
);
    logic             push_valid;
    logic [WIDTH-1:0] push_data;
    logic             push_ready;
    logic             pop_req;
    logic             pop_ready;
    logic [WIDTH-1:0] pop_data;
    logic             pop_dvalid;

    modport master (
        output push_valid, push_data, pop_req,
        input  push_ready, pop_ready, pop_data, pop_dvalid
    );

    modport slave (
        input  push_valid, push_data, pop_req,
        output push_ready, pop_ready, pop_data, pop_dvalid
    );
endinterface

// File: rtl/fifo8x9_ctrl.sv
// Sequencing controller for the FIFO8x9 array: one array control pin per cycle,
// push/pop arbitration with alternating priority, and registered occupancy.
module fifo8x9_ctrl
    import fifo8x9_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    fifo8x9_if.slave                 bus,
    output logic                     mem_wren,
    output logic                     mem_rden,
    output logic                     mem_wrinc,
    output logic                     mem_rdinc,
    output logic                     mem_wrptrclr,
    output logic                     mem_rdptrclr,
    output logic [WIDTH-1:0]         mem_din,
    input  logic [WIDTH-1:0]         mem_dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [2:0] S_INIT_R  = INIT_R;
    localparam logic [2:0] S_INIT_W  = INIT_W;
    localparam logic [2:0] S_IDLE    = IDLE;
    localparam logic [2:0] S_WR_DATA = WR_DATA;
    localparam logic [2:0] S_WR_INC  = WR_INC;
    localparam logic [2:0] S_RD_DATA = RD_DATA;
    localparam logic [2:0] S_RD_INC  = RD_INC;

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             last_pop_q, last_pop_d;
    logic [WIDTH-1:0] din_q, din_d;
    logic [WIDTH-1:0] pop_data_q, pop_data_d;

    logic is_idle;
    logic push_elig;
    logic pop_elig;
    logic sel_pop;
    logic push_go;
    logic pop_go;

    // Arbiter: pop is selected when it is the only eligible request, or when
    // both are eligible and the previous grant was a push.
    always_comb begin
        is_idle   = (state_q == S_IDLE) && !flush;
        push_elig = bus.push_valid && !full_q;
        pop_elig  = bus.pop_req && !empty_q;
        sel_pop   = pop_elig && (!push_elig || !last_pop_q);
        pop_go    = is_idle && sel_pop;
        push_go   = is_idle && !full_q && !sel_pop && bus.push_valid;
    end

    assign bus.pop_ready  = is_idle && sel_pop;
    assign bus.push_ready = is_idle && !full_q && !sel_pop;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        last_pop_d = last_pop_q;
        din_d      = din_q;
        pop_data_d = pop_data_q;
        case (state_q)
            S_INIT_R:  state_d = S_INIT_W;
            S_INIT_W:  state_d = S_IDLE;
            S_IDLE: begin
                if (pop_go) begin
                    state_d    = S_RD_DATA;
                    last_pop_d = 1'b1;
                end else if (push_go) begin
                    state_d    = S_WR_DATA;
                    last_pop_d = 1'b0;
                    din_d      = bus.push_data;
                end
            end
            S_WR_DATA: state_d = S_WR_INC;
            S_WR_INC: begin
                state_d = S_IDLE;
                count_d = count_q + CW'(1);
            end
            S_RD_DATA: begin
                state_d    = S_RD_INC;
                pop_data_d = mem_dout;
            end
            S_RD_INC: begin
                state_d = S_IDLE;
                count_d = count_q - CW'(1);
            end
            default:   state_d = S_INIT_R;
        endcase

        // Flush abandons whatever is in flight, including a pending read capture.
        if (flush) begin
            state_d    = S_INIT_R;
            count_d    = '0;
            pop_data_d = pop_data_q;
        end

        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_INIT_R;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            last_pop_q <= 1'b0;
            din_q      <= '0;
            pop_data_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            last_pop_q <= last_pop_d;
            din_q      <= din_d;
            pop_data_q <= pop_data_d;
        end
    end

    // Array controls are pure state decodes, so at most one is ever active.
    assign mem_rdptrclr = (state_q == S_INIT_R);
    assign mem_wrptrclr = (state_q == S_INIT_W);
    assign mem_wren     = (state_q == S_WR_DATA);
    assign mem_wrinc    = (state_q == S_WR_INC);
    assign mem_rden     = (state_q == S_RD_DATA);
    assign mem_rdinc    = (state_q == S_RD_INC);
    assign mem_din      = din_q;

    assign bus.pop_data   = pop_data_q;
    assign bus.pop_dvalid = (state_q == S_RD_INC) && !flush;

    assign count = count_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: tb/tb_fifo8x9_ctrl.sv
// Self-checking bench for fifo8x9_ctrl: behavioural array model, queue-based
// scoreboard with alternating-priority arbitration model, and scenario tasks.
module tb_fifo8x9_ctrl;
    import fifo8x9_pkg::*;

    localparam int W  = FIFO_WIDTH;
    localparam int D  = FIFO_DEPTH;
    localparam int CW = CNT_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    logic mem_wren, mem_rden, mem_wrinc, mem_rdinc, mem_wrptrclr, mem_rdptrclr;
    logic [W-1:0] mem_din, mem_dout;
    logic [CW-1:0] count;
    logic full, empty;

    fifo8x9_if #(.WIDTH(W)) bus ();

    fifo8x9_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus),
        .mem_wren(mem_wren), .mem_rden(mem_rden),
        .mem_wrinc(mem_wrinc), .mem_rdinc(mem_rdinc),
        .mem_wrptrclr(mem_wrptrclr), .mem_rdptrclr(mem_rdptrclr),
        .mem_din(mem_din), .mem_dout(mem_dout),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural FIFO8x9 array: 8 words, 3-bit wrapping pointers.
    logic [W-1:0] arr [D];
    logic [2:0] wr_ptr, rd_ptr;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= 3'd0;
            rd_ptr <= 3'd0;
        end else begin
            if (mem_wrptrclr) wr_ptr <= 3'd0;
            if (mem_rdptrclr) rd_ptr <= 3'd0;
            if (mem_wren)     arr[wr_ptr] <= mem_din;
            if (mem_wrinc)    wr_ptr <= wr_ptr + 3'd1;
            if (mem_rdinc)    rd_ptr <= rd_ptr + 3'd1;
        end
    end
    assign mem_dout = arr[rd_ptr];

    // Scoreboard: contents queue, pending pops with due cycle, arbitration bit.
    typedef struct { logic [W-1:0] data; int due; } pend_t;
    logic [W-1:0] q [$];
    pend_t pend [$];
    bit last_pop_m = 1'b0;

    always @(negedge clk) begin
        int n_mem, occ;
        bit pg, wg, push_e, pop_e, exp_pop;
        pend_t e;
        if (!rst) begin
            q.delete();
            pend.delete();
            last_pop_m = 1'b0;
        end else begin
            n_mem = int'(mem_wren) + int'(mem_rden) + int'(mem_wrinc) + int'(mem_rdinc)
                  + int'(mem_wrptrclr) + int'(mem_rdptrclr);
            n_cmp++;
            if (n_mem > 1 || (bus.push_ready && bus.pop_ready)) begin
                n_bad++;
                $display("FAIL exclusivity cyc=%0d mem_active=%0d push_ready=%b pop_ready=%b required mem<=1 and not both ready",
                         cyc, n_mem, bus.push_ready, bus.pop_ready);
            end
            if (flush) begin
                q.delete();
                pend.delete();
            end else begin
                pg = bus.pop_req && bus.pop_ready;
                wg = bus.push_valid && bus.push_ready;
                if (pg || wg) begin
                    occ     = q.size();
                    push_e  = bus.push_valid && (occ < D);
                    pop_e   = bus.pop_req && (occ > 0);
                    exp_pop = (push_e && pop_e) ? !last_pop_m : pop_e;
                    n_cmp++;
                    if (pg !== exp_pop || (pg && wg)) begin
                        n_bad++;
                        $display("FAIL arbitration cyc=%0d granted_pop=%b granted_push=%b required_pop=%b occ=%0d",
                                 cyc, pg, wg, exp_pop, occ);
                    end
                    n_cmp++;
                    if (count !== CW'(occ)) begin
                        n_bad++;
                        $display("FAIL count_at_grant cyc=%0d count=%0d required=%0d", cyc, count, occ);
                    end
                    if (pg && occ > 0) begin
                        e.data = q.pop_front();
                        e.due  = cyc + 2;
                        pend.push_back(e);
                        last_pop_m = 1'b1;
                    end else if (wg) begin
                        q.push_back(bus.push_data);
                        last_pop_m = 1'b0;
                    end
                end
                if (bus.pop_dvalid) begin
                    n_cmp++;
                    if (pend.size() == 0) begin
                        n_bad++;
                        $display("FAIL pop_dvalid_unexpected cyc=%0d pop_data=%h required no pulse", cyc, bus.pop_data);
                    end else begin
                        e = pend.pop_front();
                        if (bus.pop_data !== e.data || cyc != e.due) begin
                            n_bad++;
                            $display("FAIL pop_data cyc=%0d data=%h required=%h due_cyc=%0d", cyc, bus.pop_data, e.data, e.due);
                        end
                    end
                end
            end
        end
    end

    task automatic push_word(input logic [W-1:0] d);
        int n = 0;
        @(posedge clk); #1;
        bus.push_valid = 1'b1;
        bus.push_data  = d;
        @(negedge clk);
        while (!bus.push_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (!bus.push_ready) begin
            n_bad++;
            $display("FAIL push_wait data=%h push_ready=0 required=1 within 30 cycles", d);
            bus.push_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.push_valid = 1'b0;
        bus.push_data  = W'($urandom);
        @(negedge clk);
        n_cmp++;
        if (mem_wren !== 1'b1 || mem_din !== d) begin
            n_bad++;
            $display("FAIL push_wren mem_wren=%b mem_din=%h required 1/%h", mem_wren, mem_din, d);
        end
        @(negedge clk);
        n_cmp++;
        if (mem_wrinc !== 1'b1) begin
            n_bad++;
            $display("FAIL push_wrinc mem_wrinc=%b required=1", mem_wrinc);
        end
        $display("push data=%h cyc=%0d", d, cyc);
    endtask

    task automatic pop_word(output logic [W-1:0] d, output int lat);
        int n = 0;
        int t0;
        d   = 'x;
        lat = -1;
        @(posedge clk); #1;
        bus.pop_req = 1'b1;
        @(negedge clk);
        while (!bus.pop_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (!bus.pop_ready) begin
            n_bad++;
            $display("FAIL pop_wait pop_ready=0 required=1 within 30 cycles");
            bus.pop_req = 1'b0;
            return;
        end
        t0 = cyc;
        @(posedge clk); #1;
        bus.pop_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (mem_rden !== 1'b1) begin
            n_bad++;
            $display("FAIL pop_rden mem_rden=%b required=1", mem_rden);
        end
        n = 0;
        while (!bus.pop_dvalid && n < 6) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (!bus.pop_dvalid) begin
            n_bad++;
            $display("FAIL pop_dvalid_timeout pop_dvalid=0 required=1 within 6 cycles");
            return;
        end
        d   = bus.pop_data;
        lat = cyc - t0;
        $display("pop  data=%h latency=%0d cyc=%0d", d, lat, cyc);
    endtask

    task automatic test_reset();
        logic [CW+W+4:0] got, want;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.push_valid = 1'b1;
        bus.pop_req    = 1'b1;
        @(negedge clk);
        got  = {count, empty, full, bus.pop_data, bus.pop_dvalid, bus.push_ready, bus.pop_ready};
        want = {CW'(0), 1'b1, 1'b0, W'(0), 1'b0, 1'b0, 1'b0};
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL reset_outputs got=%h required=%h", got, want);
        end
        n_cmp++;
        if ({mem_rdptrclr, mem_wrptrclr, mem_wren, mem_rden, mem_wrinc, mem_rdinc} !== 6'b100000
            || mem_din !== W'(0)) begin
            n_bad++;
            $display("FAIL reset_mem ctl=%b din=%h required 100000/0",
                     {mem_rdptrclr, mem_wrptrclr, mem_wren, mem_rden, mem_wrinc, mem_rdinc}, mem_din);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        bus.push_valid = 1'b0;
        bus.pop_req    = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (mem_rdptrclr !== 1'b1 || bus.push_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL init_r rdptrclr=%b push_ready=%b required 1/0", mem_rdptrclr, bus.push_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (mem_wrptrclr !== 1'b1 || mem_rdptrclr !== 1'b0 || bus.push_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL init_w wrptrclr=%b rdptrclr=%b push_ready=%b required 1/0/0",
                     mem_wrptrclr, mem_rdptrclr, bus.push_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.push_ready !== 1'b1 || empty !== 1'b1 || count !== CW'(0)) begin
            n_bad++;
            $display("FAIL idle_after_init push_ready=%b empty=%b count=%0d required 1/1/0",
                     bus.push_ready, empty, count);
        end
        $display("reset sequence done cyc=%0d", cyc);
    endtask

    task automatic test_fill();
        for (int i = 1; i <= D; i++) push_word(W'(i));
        @(negedge clk);
        n_cmp++;
        if (full !== 1'b1 || count !== CW'(D)) begin
            n_bad++;
            $display("FAIL fill_full full=%b count=%0d required 1/%0d", full, count, D);
        end
        @(posedge clk); #1;
        bus.push_valid = 1'b1;
        bus.push_data  = W'(9'h0FF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.push_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL push_when_full push_ready=%b required=0", bus.push_ready);
            end
        end
        #1 bus.pop_req = 1'b1;
        #1;
        n_cmp++;
        if (bus.pop_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL pop_ready_when_full pop_ready=%b required=1", bus.pop_ready);
        end
        bus.pop_req    = 1'b0;
        bus.push_valid = 1'b0;
    endtask

    task automatic test_drain();
        logic [W-1:0] d;
        int lat;
        for (int i = 1; i <= D; i++) begin
            pop_word(d, lat);
            n_cmp++;
            if (d !== W'(i) || lat != 2) begin
                n_bad++;
                $display("FAIL drain_order data=%h latency=%0d required %h/2", d, lat, W'(i));
            end
        end
        @(negedge clk);
        n_cmp++;
        if (empty !== 1'b1 || count !== CW'(0)) begin
            n_bad++;
            $display("FAIL drain_empty empty=%b count=%0d required 1/0", empty, count);
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] d;
        logic [W-1:0] base;
        int lat;
        base = W'(9'h1A0);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 5 + r; i++) push_word(base + W'(i));
            for (int i = 0; i < 5 + r; i++) begin
                pop_word(d, lat);
                n_cmp++;
                if (d !== base + W'(i) || lat != 2) begin
                    n_bad++;
                    $display("FAIL wrap_order round=%0d data=%h latency=%0d required %h/2", r, d, lat, base + W'(i));
                end
            end
        end
        @(negedge clk);
        n_cmp++;
        if (count !== CW'(0) || empty !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap_count count=%0d empty=%b required 0/1", count, empty);
        end
    endtask

    task automatic test_contention();
        int grants = 0;
        int n = 0;
        bit exp_pop;
        for (int i = 0; i < 3; i++) push_word(W'($urandom));
        @(negedge clk);
        @(posedge clk); #1;
        bus.push_valid = 1'b1;
        bus.pop_req    = 1'b1;
        bus.push_data  = W'($urandom);
        while (grants < 6 && n < 60) begin
            @(negedge clk);
            n++;
            if (bus.pop_ready || bus.push_ready) begin
                exp_pop = (grants % 2 == 0);
                n_cmp++;
                if (bus.pop_ready !== exp_pop || count !== CW'(exp_pop ? 3 : 2)) begin
                    n_bad++;
                    $display("FAIL contention grant=%0d pop=%b count=%0d required pop=%b count=%0d",
                             grants, bus.pop_ready, count, exp_pop, exp_pop ? 3 : 2);
                end
                $display("contention grant=%0d %s count=%0d", grants, bus.pop_ready ? "pop" : "push", count);
                grants++;
            end
        end
        n_cmp++;
        if (grants != 6) begin
            n_bad++;
            $display("FAIL contention_timeout grants=%0d required=6", grants);
        end
        @(posedge clk); #1;
        bus.push_valid = 1'b0;
        bus.pop_req    = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (count !== CW'(3)) begin
            n_bad++;
            $display("FAIL contention_final count=%0d required=3", count);
        end
    endtask

    task automatic test_flush();
        logic [W-1:0] d, x;
        int lat;
        push_word(W'($urandom));
        @(negedge clk);
        n_cmp++;
        if (count !== CW'(4)) begin
            n_bad++;
            $display("FAIL flush_setup count=%0d required=4", count);
        end
        @(posedge clk); #1;
        bus.pop_req = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.pop_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_pop_accept pop_ready=%b required=1", bus.pop_ready);
        end
        @(posedge clk); #1;
        bus.pop_req = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (mem_rden !== 1'b1 || bus.pop_dvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_rd_data rden=%b dvalid=%b required 1/0", mem_rden, bus.pop_dvalid);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({mem_rdptrclr, bus.pop_dvalid, empty} !== 3'b101 || count !== CW'(0)) begin
            n_bad++;
            $display("FAIL flush_init_r rdptrclr=%b dvalid=%b empty=%b count=%0d required 1/0/1/0",
                     mem_rdptrclr, bus.pop_dvalid, empty, count);
        end
        @(negedge clk);
        n_cmp++;
        if (mem_wrptrclr !== 1'b1 || bus.pop_dvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_init_w wrptrclr=%b dvalid=%b required 1/0", mem_wrptrclr, bus.pop_dvalid);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.push_ready !== 1'b1 || count !== CW'(0)) begin
            n_bad++;
            $display("FAIL flush_idle push_ready=%b count=%0d required 1/0", bus.push_ready, count);
        end
        x = W'($urandom);
        push_word(x);
        pop_word(d, lat);
        n_cmp++;
        if (d !== x || lat != 2) begin
            n_bad++;
            $display("FAIL flush_roundtrip data=%h latency=%0d required %h/2", d, lat, x);
        end
    endtask

    task automatic test_mid_reset();
        @(posedge clk); #1;
        bus.push_valid = 1'b1;
        bus.push_data  = W'($urandom);
        @(negedge clk);
        n_cmp++;
        if (bus.push_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_reset_accept push_ready=%b required=1", bus.push_ready);
        end
        @(posedge clk); #1;
        bus.push_valid = 1'b0;
        test_reset();
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            bus.push_valid = 1'($urandom_range(0, 1));
            bus.pop_req    = 1'($urandom_range(0, 1));
            bus.push_data  = W'($urandom);
        end
        @(posedge clk); #1;
        bus.push_valid = 1'b0;
        bus.pop_req    = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (count !== CW'(q.size()) || full !== (q.size() == D) || empty !== (q.size() == 0)) begin
            n_bad++;
            $display("FAIL random_final count=%0d full=%b empty=%b required count=%0d", count, full, empty, q.size());
        end
        $display("random run done occupancy=%0d", q.size());
    endtask

    initial begin
        bus.push_valid = 1'b0;
        bus.push_data  = '0;
        bus.pop_req    = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_contention();
        test_flush();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d bench did not complete", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
